// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: FSM states, PID/SYNC bytes, CRC16 constants, line states.
// The CRC16 helper is used only when TX_CRC16_EN is defined.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;
  localparam logic [2:0] PKT_STALL = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // PID byte for a latched packet code
  function automatic logic [7:0] pid_byte(input logic [2:0] pkt);
    case (pkt)
      PKT_DATA0: return PID_DATA0;
      PKT_DATA1: return PID_DATA1;
      PKT_ACK:   return PID_ACK;
      PKT_NAK:   return PID_NAK;
      default:   return PID_STALL;
    endcase
  endfunction

  // One serial CRC16 step for a single payload bit
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    if (bit_in ^ crc[15]) return {crc[14:0], 1'b0} ^ CRC16_POLY;
    return {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/usb_tx_bit_encoder.sv
// Bit-period timer, bit stuffing and NRZI line driver for the USB transmitter.
// i_start restarts the timer and emits a bit immediately; otherwise the line changes only on bit ticks.
// Configuration: unaffected by TX_CRC16_EN.
module usb_tx_bit_encoder
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_bit_valid,
  input  logic i_bit_val,
  input  logic i_force_se0,
  input  logic i_force_j,
  output logic o_bit_tick_c,
  output logic o_stuff_slot_c,
  output logic o_dp_out,
  output logic o_dm_out
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  logic [TW-1:0] r_timer;
  logic [1:0]    r_line;
  logic [2:0]    r_ones;
  logic [1:0]    w_line_nxt;
  logic [2:0]    w_ones_nxt;
  logic [2:0]    w_ones_base;
  logic          w_tick;
  logic          w_stuff;

  assign w_tick         = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_stuff        = w_tick && !i_start && (r_ones == 3'd6);
  assign o_bit_tick_c   = w_tick;
  assign o_stuff_slot_c = w_stuff;
  assign o_dp_out       = r_line[1];
  assign o_dm_out       = r_line[0];

  // Next line level and ones-run count at a bit-period start
  always_comb begin
    w_line_nxt  = r_line;
    w_ones_nxt  = r_ones;
    w_ones_base = i_start ? 3'd0 : r_ones;
    if (i_start || w_tick) begin
      if (w_stuff) begin
        w_line_nxt = {r_line[0], r_line[1]};
        w_ones_nxt = 3'd0;
      end else if (i_force_se0) begin
        w_line_nxt = LINE_SE0;
        w_ones_nxt = 3'd0;
      end else if (i_force_j) begin
        w_line_nxt = LINE_J;
        w_ones_nxt = 3'd0;
      end else if (i_bit_valid) begin
        if (i_bit_val) begin
          w_ones_nxt = w_ones_base + 3'd1;
        end else begin
          w_line_nxt = {r_line[0], r_line[1]};
          w_ones_nxt = 3'd0;
        end
      end
    end
  end

  // Timer, line and ones-run registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
      r_line  <= LINE_J;
      r_ones  <= 3'd0;
    end else begin
      r_timer <= (i_start || w_tick) ? '0 : r_timer + TW'(1);
      r_line  <= w_line_nxt;
      r_ones  <= w_ones_nxt;
    end
  end

endmodule

// File: rtl/usb_tx_controller.sv
// USB full-speed packet transmitter: SYNC, PID, payload, optional CRC16, EOP.
// TX_CRC16_EN: when defined, CRC16 is generated and appended to DATA packets;
// when undefined, the buffer supplies the two CRC bytes as part of the payload.
module usb_tx_controller
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_BYTES    = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_start,
  input  logic [2:0] i_tx_packet,
  input  logic [6:0] i_buffer_occupancy,
  input  logic [7:0] i_tx_packet_data,
  output logic       o_get_tx_packet_data,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx_error,
  output logic       o_dp_out,
  output logic       o_dm_out
);

  tx_state_t  r_state, w_state_nxt;
  logic [2:0] r_pkt, w_pkt_nxt;
  logic [6:0] r_nbytes, w_nbytes_nxt;
  logic [6:0] r_byte_cnt, w_byte_cnt_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt, w_field_last;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_error, w_error_nxt;
`ifdef TX_CRC16_EN
  logic [15:0] r_crc, w_crc_nxt;
`endif

  logic [7:0] w_pid;
  logic       w_is_data, w_req_data, w_req_ok;
  logic       w_start, w_bit_valid, w_bit_val, w_force_se0, w_force_j, w_get;
  logic       w_bit_tick, w_stuff_slot, w_adv, w_go_tail, w_go_eop;

  assign w_pid      = pid_byte(r_pkt);
  assign w_is_data  = (r_pkt == PKT_DATA0) || (r_pkt == PKT_DATA1);
  assign w_req_data = (i_tx_packet == PKT_DATA0) || (i_tx_packet == PKT_DATA1);
  assign w_req_ok   = (i_tx_packet >= PKT_DATA0) && (i_tx_packet <= PKT_STALL) &&
                      !(w_req_data && (i_buffer_occupancy > 7'(MAX_BYTES)));
  assign w_adv      = w_bit_tick && !w_stuff_slot;

  assign o_get_tx_packet_data = w_get;
  assign o_tx_busy            = r_busy;
  assign o_tx_done            = r_done;
  assign o_tx_error           = r_error;

  // Index of the last bit in the current field
  always_comb begin
    w_field_last = 4'd7;
    case (r_state)
      ST_CRC:     w_field_last = 4'd15;
      ST_EOP_SE0: w_field_last = 4'd1;
      ST_EOP_J:   w_field_last = 4'd0;
      default:    w_field_last = 4'd7;
    endcase
  end

  // Next-state, field sequencing and bit selection for the encoder
  always_comb begin
    w_state_nxt    = r_state;
    w_pkt_nxt      = r_pkt;
    w_nbytes_nxt   = r_nbytes;
    w_byte_cnt_nxt = r_byte_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
`ifdef TX_CRC16_EN
    w_crc_nxt      = r_crc;
`endif
    w_start        = 1'b0;
    w_bit_valid    = 1'b0;
    w_bit_val      = 1'b0;
    w_force_se0    = 1'b0;
    w_force_j      = 1'b0;
    w_get          = 1'b0;
    w_go_tail      = 1'b0;
    w_go_eop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_tx_start) begin
          if (w_req_ok) begin
            w_pkt_nxt      = i_tx_packet;
            w_nbytes_nxt   = i_buffer_occupancy;
            w_byte_cnt_nxt = 7'd0;
            w_busy_nxt     = 1'b1;
            w_start        = 1'b1;
            w_state_nxt    = ST_SYNC;
            w_bit_valid    = 1'b1;
            w_bit_val      = SYNC_BYTE[0];
            w_shift_nxt    = {1'b0, SYNC_BYTE[7:1]};
            w_bit_cnt_nxt  = 4'd0;
`ifdef TX_CRC16_EN
            w_crc_nxt      = CRC16_INIT;
`endif
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (w_adv) begin
          if (r_bit_cnt != w_field_last) begin
            // Continue the current field
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_state == ST_EOP_SE0) begin
              w_force_se0 = 1'b1;
`ifdef TX_CRC16_EN
            end else if (r_state == ST_CRC) begin
              w_bit_valid = 1'b1;
              w_bit_val   = ~r_crc[15];
              w_crc_nxt   = {r_crc[14:0], 1'b0};
`endif
            end else begin
              w_bit_valid = 1'b1;
              w_bit_val   = r_shift[0];
              w_shift_nxt = {1'b0, r_shift[7:1]};
`ifdef TX_CRC16_EN
              if (r_state == ST_DATA) w_crc_nxt = crc16_step(r_crc, r_shift[0]);
`endif
            end
          end else begin
            // Field finished: start the next one in this same bit period
            w_bit_cnt_nxt = 4'd0;
            case (r_state)
              ST_SYNC: begin
                w_state_nxt = ST_PID;
                w_bit_valid = 1'b1;
                w_bit_val   = w_pid[0];
                w_shift_nxt = {1'b0, w_pid[7:1]};
              end
              ST_PID, ST_DATA: begin
                if ((r_state == ST_PID) && !w_is_data) begin
                  w_go_eop = 1'b1;
                end else if (r_byte_cnt == r_nbytes) begin
                  w_go_tail = 1'b1;
                end else begin
                  w_state_nxt    = ST_DATA;
                  w_get          = 1'b1;
                  w_byte_cnt_nxt = r_byte_cnt + 7'd1;
                  w_bit_valid    = 1'b1;
                  w_bit_val      = i_tx_packet_data[0];
                  w_shift_nxt    = {1'b0, i_tx_packet_data[7:1]};
`ifdef TX_CRC16_EN
                  w_crc_nxt      = crc16_step(r_crc, i_tx_packet_data[0]);
`endif
                end
              end
              ST_EOP_SE0: begin
                w_state_nxt = ST_EOP_J;
                w_force_j   = 1'b1;
              end
              ST_EOP_J: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
              end
              default: w_go_eop = 1'b1;
            endcase
          end
        end
      end
    endcase

`ifdef TX_CRC16_EN
    if (w_go_tail) begin
      w_state_nxt = ST_CRC;
      w_bit_valid = 1'b1;
      w_bit_val   = ~r_crc[15];
      w_crc_nxt   = {r_crc[14:0], 1'b0};
    end
    if (w_go_eop) begin
      w_state_nxt = ST_EOP_SE0;
      w_force_se0 = 1'b1;
    end
`else
    if (w_go_tail || w_go_eop) begin
      w_state_nxt = ST_EOP_SE0;
      w_force_se0 = 1'b1;
    end
`endif
  end

  // State, counters, shift register and status strobes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pkt      <= 3'd0;
      r_nbytes   <= 7'd0;
      r_byte_cnt <= 7'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef TX_CRC16_EN
      r_crc      <= CRC16_INIT;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pkt      <= w_pkt_nxt;
      r_nbytes   <= w_nbytes_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
`ifdef TX_CRC16_EN
      r_crc      <= w_crc_nxt;
`endif
    end
  end

  usb_tx_bit_encoder #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_enc (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (w_start),
    .i_bit_valid    (w_bit_valid),
    .i_bit_val      (w_bit_val),
    .i_force_se0    (w_force_se0),
    .i_force_j      (w_force_j),
    .o_bit_tick_c   (w_bit_tick),
    .o_stuff_slot_c (w_stuff_slot),
    .o_dp_out       (o_dp_out),
    .o_dm_out       (o_dm_out)
  );

endmodule

// File: tb/tb_usb_tx_controller.sv
// Directed bench for usb_tx_controller: line waveform per bit period, pops, done/error timing.
// Expected line levels come from a small stuffing/NRZI model fed with hand-written byte lists
// (SYNC, PID, payload and the hand-computed CRC bytes).
module tb_usb_tx_controller;

`ifdef TX_CRC16_EN
  localparam int CRC_IN_BUF = 0;
`else
  localparam int CRC_IN_BUF = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] occupancy = 7'd0;
  logic [7:0] tx_data;
  logic       get, busy, done, err, dp, dm;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rd_idx = 8'd0;
  int         pop_total = 0;

  logic [7:0] pkt_bytes [0:7];
  int         pkt_len;
  logic [1:0] exp_ln [0:127];
  int         exp_n;

  always #5 clk = ~clk;

  assign tx_data = mem[rd_idx];

  // Buffer model: FWFT head advances on each pop strobe
  always @(posedge clk) begin
    if (get) begin
      rd_idx    <= rd_idx + 8'd1;
      pop_total <= pop_total + 1;
    end
  end

  usb_tx_controller dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_tx_start           (tx_start),
    .i_tx_packet          (tx_packet),
    .i_buffer_occupancy   (occupancy),
    .i_tx_packet_data     (tx_data),
    .o_get_tx_packet_data (get),
    .o_tx_busy            (busy),
    .o_tx_done            (done),
    .o_tx_error           (err),
    .o_dp_out             (dp),
    .o_dm_out             (dm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stuffing + NRZI model producing the {dp,dm} level of every bit period
  task automatic build_expected();
    logic lvl;
    logic b;
    int   ones;
    lvl   = 1'b1;
    ones  = 0;
    exp_n = 0;
    for (int j = 0; j < pkt_len; j++) begin
      for (int i = 0; i < 8; i++) begin
        b = pkt_bytes[j][i];
        if (!b) begin
          lvl  = ~lvl;
          ones = 0;
        end else begin
          ones++;
        end
        exp_ln[exp_n] = {lvl, ~lvl};
        exp_n++;
        if (ones == 6) begin
          lvl  = ~lvl;
          ones = 0;
          exp_ln[exp_n] = {lvl, ~lvl};
          exp_n++;
        end
      end
    end
    exp_ln[exp_n]     = 2'b00;
    exp_ln[exp_n + 1] = 2'b00;
    exp_ln[exp_n + 2] = 2'b10;
    exp_n += 3;
  endtask

  task automatic send(input string tag, input logic [2:0] code, input logic [6:0] occ,
                      input int exp_pops, input int retrig_cyc);
    int pops0;
    build_expected();
    pops0 = pop_total;
    @(posedge clk); #1;
    tx_start  = 1'b1;
    tx_packet = code;
    occupancy = occ;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk($sformatf("%s_busy_on", tag), 32'(busy), 32'd1);
    chk($sformatf("%s_no_err", tag), 32'(err), 32'd0);
    for (int c = 0; c < exp_n * 8; c++) begin
      if (c % 8 == 4)
        chk($sformatf("%s_line_p%0d", tag, c / 8), 32'({dp, dm}), 32'(exp_ln[c / 8]));
      tx_start = (c == retrig_cyc);
      if (c == retrig_cyc) tx_packet = 3'd3;
      else tx_packet = code;
      @(posedge clk); #1;
    end
    chk($sformatf("%s_done", tag), 32'(done), 32'd1);
    chk($sformatf("%s_busy_off", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_idle_j", tag), 32'({dp, dm}), 32'd2);
    chk($sformatf("%s_pops", tag), 32'(pop_total - pops0), 32'(exp_pops));
    @(posedge clk); #1;
    chk($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s_still_idle", tag), 32'(busy), 32'd0);
  endtask

  task automatic req_err(input string tag, input logic [2:0] code, input logic [6:0] occ);
    @(posedge clk); #1;
    tx_start  = 1'b1;
    tx_packet = code;
    occupancy = occ;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk($sformatf("%s_err", tag), 32'(err), 32'd1);
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_line", tag), 32'({dp, dm}), 32'd2);
    @(posedge clk); #1;
    chk($sformatf("%s_err_pulse", tag), 32'(err), 32'd0);
    chk($sformatf("%s_busy2", tag), 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk($sformatf("%s_line2", tag), 32'({dp, dm}), 32'd2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", 32'({dp, dm}), 32'd2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_get", 32'(get), 32'd0);
    rst = 1'b0;

    // ACK: 19 bit periods
    pkt_len = 2; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'hD2;
    send("ack", 3'd3, 7'd0, 0, -1);

    // STALL
    pkt_len = 2; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'h1E;
    send("stall", 3'd5, 7'd0, 0, -1);

    // DATA0 with one 0xFF byte; CRC16 of 0xFF sent as bytes 0x00, 0xFF
    pkt_len = 5; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'hC3; pkt_bytes[2] = 8'hFF;
    pkt_bytes[3] = 8'h00; pkt_bytes[4] = 8'hFF;
    mem[rd_idx] = 8'hFF;
    if (CRC_IN_BUF != 0) begin
      mem[rd_idx + 8'd1] = 8'h00;
      mem[rd_idx + 8'd2] = 8'hFF;
    end
    send("data0_ff", 3'd1, 7'(1 + CRC_IN_BUF), 1 + CRC_IN_BUF, -1);

    // DATA1 zero-length: CRC field is sixteen zeros
    pkt_len = 4; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'h4B;
    pkt_bytes[2] = 8'h00; pkt_bytes[3] = 8'h00;
    if (CRC_IN_BUF != 0) begin
      mem[rd_idx]        = 8'h00;
      mem[rd_idx + 8'd1] = 8'h00;
    end
    send("data1_zlp", 3'd2, 7'(CRC_IN_BUF), CRC_IN_BUF, -1);

    // Retrigger during the payload is ignored
    pkt_len = 5; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'hC3; pkt_bytes[2] = 8'hFF;
    pkt_bytes[3] = 8'h00; pkt_bytes[4] = 8'hFF;
    mem[rd_idx] = 8'hFF;
    if (CRC_IN_BUF != 0) begin
      mem[rd_idx + 8'd1] = 8'h00;
      mem[rd_idx + 8'd2] = 8'hFF;
    end
    send("retrig", 3'd1, 7'(1 + CRC_IN_BUF), 1 + CRC_IN_BUF, 8 * 18 + 2);

    // Rejected requests
    req_err("err_code0", 3'd0, 7'd0);
    req_err("err_code6", 3'd6, 7'd0);
    req_err("err_occ65", 3'd1, 7'd65);

    // Reset in the middle of the payload
    for (int i = 0; i < 4; i++) mem[rd_idx + 8'(i)] = 8'hA5;
    @(posedge clk); #1;
    tx_start = 1'b1; tx_packet = 3'd1; occupancy = 7'd4;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    repeat (8 * 20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_line", 32'({dp, dm}), 32'd2);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_get", 32'(get), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_line", 32'({dp, dm}), 32'd2);

    // Normal ACK after reset
    pkt_len = 2; pkt_bytes[0] = 8'h80; pkt_bytes[1] = 8'hD2;
    send("ack2", 3'd3, 7'd0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
